// File: rtl/mem_pkg.sv
// Shared memory-model definitions: default geometry, the delay-line stage
// record, and the cache-block size that the fill logic also uses.
package mem_pkg;

   localparam int unsigned MEM_LATENCY     = 4;
   localparam int unsigned MEM_ADDR_W      = 16;
   localparam int unsigned MEM_DATA_W      = 16;
   localparam int unsigned MEM_BLOCK_WORDS = 8;

   typedef struct packed {
      logic                  valid;
      logic [MEM_DATA_W-1:0] data;
   } mem_stage_t;

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-depth read-return pipe: every stage shifts every cycle, with no stall.
// Reset clears all stages so that in-flight reads are discarded.
module mem_delay_line
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY = MEM_LATENCY,
   parameter type         stage_t = mem_stage_t
) (
   input  logic   clk,
   input  logic   rst,
   input  stage_t stage_in,
   output stage_t stage_out
);

   stage_t stage_q [LATENCY];
   stage_t stage_d [LATENCY];

   always_comb begin
      stage_d[0] = stage_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign stage_out = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_burst_responder.sv
// Main-memory model: word array, request decode, a fixed-latency return pipe
// and a count of reads still in flight.
module mem_burst_responder
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY    = MEM_LATENCY,
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic [2:0]            outstanding
);

   localparam int unsigned WORDS   = 2 ** (ADDR_WIDTH - 1);
   localparam logic [2:0]  OUT_MAX = 3'(LATENCY);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [ADDR_WIDTH-2:0] word_idx;
   logic                  issue_rd;
   logic                  unused_addr_lsb;
   stage_t                stage_in;
   stage_t                stage_out;
   logic [2:0]            outstanding_q;
   logic [2:0]            outstanding_d;

   assign word_idx        = addr[ADDR_WIDTH-1:1];
   assign unused_addr_lsb = addr[0];
   assign issue_rd        = enable & ~wr;

   // Reset drops the request, so a write in a reset cycle leaves the array alone.
   always_ff @(posedge clk) begin
      if (!rst && enable && wr) begin
         mem_q[word_idx] <= data_in;
      end
   end

   always_comb begin
      stage_in = '0;
      if (issue_rd) begin
         stage_in.valid = 1'b1;
         stage_in.data  = mem_q[word_idx];
      end
   end

   mem_delay_line #(
      .LATENCY (LATENCY),
      .stage_t (stage_t)
   ) u_delay_line (
      .clk       (clk),
      .rst       (rst),
      .stage_in  (stage_in),
      .stage_out (stage_out)
   );

   always_comb begin
      outstanding_d = outstanding_q;
      if (issue_rd && !stage_out.valid && outstanding_q != OUT_MAX) begin
         outstanding_d = outstanding_q + 3'd1;
      end else if (!issue_rd && stage_out.valid && outstanding_q != '0) begin
         outstanding_d = outstanding_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   assign data_valid  = stage_out.valid;
   assign data_out    = stage_out.valid ? stage_out.data : '0;
   assign outstanding = outstanding_q;

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Multicycle main-memory model that answers cache-fill read streams and pipeline writes. One request per cycle is accepted. A read returns its word exactly LATENCY cycles later, with a one-cycle `data_valid` pulse per word. Back-to-back reads therefore stream back-to-back. It sits between the cache-control fill logic (and the write-through path) and the memory array, at the responder end of the `memory_address` / `memory_data_valid` protocol.

## Interface
- LATENCY, 4: cycles from request to data return, ≥1
- ADDR_WIDTH, 16: byte address width
- DATA_WIDTH, 16: word width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  request valid this cycle
- `wr`  in  1  1 = write, 0 = read; meaningful only when `enable`=1
- `addr`  in  ADDR_WIDTH  byte address; bit 0 ignored (word-aligned)
- `data_in`  in  DATA_WIDTH  write data
- `data_out`  out  DATA_WIDTH  returned read data; 0 when `data_valid`=0
- `data_valid`  out  1  high for exactly one cycle per returned read word
- `outstanding`  out  3  reads issued but not yet returned, saturating at LATENCY

## Operation
- **Array.** 2^(ADDR_WIDTH-1) words, indexed by `addr[ADDR_WIDTH-1:1]`. The array is not cleared by `rst`. Contents are X until written.
- **Write.** Occurs when `enable`=1 and `wr`=1. The array is updated at that clock edge. Writes produce no `data_valid` and have no latency.
- **Read.** Occurs when `enable`=1 and `wr`=0. The word is read from the array at the issuing edge and captured into stage 0 of a LATENCY-deep delay line. Each stage holds {valid, data}, and every stage shifts every cycle; there is no stall.
  - A write issued after the read does not alter the value in flight.
  - A read issued the cycle after a write to the same word returns the new value.
- **Idle.** `enable`=0 injects a bubble (valid=0) into stage 0.
- **Outputs.** The last stage drives `data_valid` and `data_out`. `data_out` is forced to 0 when that stage's valid=0.
- **`outstanding` counter.**
  - +1 on a read issue, −1 on a `data_valid` cycle.
  - Both in the same cycle: unchanged.
  - Never exceeds LATENCY and never underflows.
- **Ordering.** Responses return strictly in issue order, with no reordering and no merging.
- **Reset.**
  - Synchronous: every delay-line valid bit clears, `outstanding`=0, and `data_valid`/`data_out`=0 from the cycle after the reset edge.
  - A request presented in a cycle with `rst`=1 is dropped. That includes writes: the array is not modified.
  - Reads in flight at reset never return. The initiator is responsible for reissuing them.

## Timing
- **Read latency.** A read sampled at edge n appears with `data_valid`=1 in the cycle after edge n+LATENCY−1, i.e. LATENCY cycles after the issue cycle.
  - LATENCY=4: issue in cycle 0 → `data_valid` in cycle 4.
- **Throughput.** One read per cycle. Eight consecutive issue cycles yield eight consecutive `data_valid` cycles, which covers a full cache block of 8 words at offsets 0x0, 0x2, …, 0xE.
- **Pulse width.** `data_valid` is a single-cycle pulse per request. It is never held high across a non-issued slot.
- **Output reset values.** `data_out`=0, `data_valid`=0, `outstanding`=0.
- **Read/write mixing.** A read and a write to different words may be interleaved cycle by cycle. Write slots produce bubbles in the return stream.
- **Address wrap.** The word index wraps naturally at the top of the array, with no error.

## Structure
- **Shared package `mem_pkg`** holds:
  - `MEM_LATENCY`=4, `MEM_ADDR_W`=16, `MEM_DATA_W`=16
  - typedef `mem_stage_t` = packed {valid, data}
  - the cache-block word count (8), which the cache-fill logic also uses
- **Sub-module `mem_delay_line`:** a parameterised LATENCY-stage shift register of `mem_stage_t`, synchronous clear on `rst`.
- **Top level** holds the array, the issue decode and the `outstanding` counter.

## Test plan
- **Single read.** Write 0xBEEF to 0x1234, idle one cycle, read 0x1234 in cycle c.
  - Expect `data_valid`=1 with `data_out`=0xBEEF only in cycle c+4.
  - Expect `data_out`=0 in all other cycles.
- **Block fill.** Preload 0x4000–0x400E with 0xA000+offset, then read the 8 words in 8 consecutive cycles.
  - Expect 8 consecutive `data_valid` cycles returning 0xA000, 0xA002, …, 0xA00E in order.
  - Expect `outstanding` to peak at 4.
- **Write after read.** Read 0x0010 (holds 0x1111) in cycle c, then write 0x2222 to 0x0010 in cycle c+1.
  - Expect the return in c+4 = 0x1111.
  - Expect a read in c+2 to return 0x2222 in c+6.
- **Gapped stream.** Read, idle, read, write, read.
  - Expect `data_valid` pattern 1,0,1,0,1 starting 4 cycles after the first issue.
  - Expect no `data_valid` caused by the write.
- **Reset mid-fill.** Issue 3 reads, assert `rst` in the next cycle together with a write of 0x5555 to 0x0020.
  - Expect `data_valid` to stay 0 for all following cycles and `outstanding`=0.
  - Expect a later read of 0x0020 not to return 0x5555.
- **Odd address.** Read 0x1235 after writing 0xBEEF to 0x1234.
  - Expect 0xBEEF, since bit 0 is ignored.
